shift_req_queue: RTL and testbench
==================================

// Module: shift_req_queue
// PURPOSE
//  Request buffer and result register placed directly upstream of the 8-bit combinational barrelshifter.
//  Accepts {data, shift amount} requests on a valid/ready interface and queues them in a DEPTH-entry FIFO.
//  Drives the FIFO head onto the shifter's in/ctrl pins and captures the shifter's out into a registered
//  response stage with its own valid/ready handshake. Turns the combinational shifter into a
//  flow-controlled, 1-result-per-cycle pipeline stage.
// PARAMETERS
//  DATA_W  8  data width; matches the shifter in/out width
//  CTRL_W  3  shift-amount width; matches the shifter ctrl width
//  DEPTH   4  FIFO entries; power of two, >=2
// PORTS
//  clk         in   1                 single clock, rising edge
//  rst_n       in   1                 asynchronous reset, active low
//  req_valid   in   1                 request present
//  req_ready   out  1                 FIFO can accept; = !full (combinational from state only)
//  req_data    in   DATA_W            word to shift
//  req_shamt   in   CTRL_W            shift amount
//  sh_in       out  DATA_W            to shifter in: FIFO head data
//  sh_ctrl     out  CTRL_W            to shifter ctrl: FIFO head shamt
//  sh_out      in   DATA_W            from shifter out (combinational return path)
//  rsp_valid   out  1                 response register holds a result
//  rsp_ready   in   1                 consumer accepts response
//  rsp_data    out  DATA_W            registered shifter result
//  rsp_shamt   out  CTRL_W            shift amount that produced rsp_data (echo)
//  count       out  $clog2(DEPTH)+1   FIFO occupancy, 0..DEPTH (excludes response register)
// BEHAVIOUR
//  Reset (rst_n=0, async): wr/rd pointers=0, count=0, rsp_valid=0, rsp_data=0, rsp_shamt=0.
//    FIFO contents discarded. After release, req_ready=1 and the next edge may accept.
//  Push: req_valid&&req_ready at a rising edge writes the entry at wr_ptr.
//    wr_ptr wraps DEPTH-1 -> 0.
//  Full (count==DEPTH): req_ready=0 and no write occurs, even if a pop happens in the same cycle.
//  Head: when count>0, sh_in/sh_ctrl = entry[rd_ptr]. When empty, both are driven 0.
//  Load condition: load = (count>0) && (!rsp_valid || rsp_ready).
//    On load at an edge: rsp_data<=sh_out, rsp_shamt<=sh_ctrl, rsp_valid<=1, rd_ptr advances (wraps).
//  Drain: rsp_valid && rsp_ready && count==0 at an edge -> rsp_valid<=0. rsp_data/rsp_shamt hold their values.
//  Stall: while rsp_valid && !rsp_ready, rsp_data, rsp_shamt and rsp_valid hold stable; the FIFO keeps filling.
//  Occupancy update per edge:
//    push only        -> count+1
//    load only        -> count-1
//    push and load    -> unchanged
//  Push into an empty FIFO and load of that entry never occur on the same edge.
//  Latency: request accepted at edge N (FIFO empty, response stage free) -> rsp_valid=1 after edge N+1.
//  Throughput: 1 result/cycle when rsp_ready=1.
//  Total buffering: DEPTH entries plus 1 response register.
//  Ordering: responses leave strictly in acceptance order. No drops, no duplicates.
//  Shifter contract: barrelshifter is a logical right shift by ctrl with zero fill (128,4 -> 8).
//    This block does not check the result; it forwards sh_out as returned.
// TESTING (bench instantiates shift_req_queue + barrelshifter in loop-back)
//  1 Reset: rst_n=0 -> rsp_valid=0, rsp_data=0, count=0, req_ready=1, sh_in=0, sh_ctrl=0.
//  2 Single request: push (128,4) into empty queue, rsp_ready=1
//      -> rsp_valid=1 one cycle later, rsp_data=8, rsp_shamt=4; then rsp_valid=0.
//  3 Stream: push (128,4),(128,2),(128,1),(255,7),(128,3),(128,5),(255,4) back-to-back, rsp_ready=1
//      -> rsp_data = 8,32,64,1,16,4,15 on consecutive cycles, in order.
//  4 Backpressure: rsp_ready=0, offer 6 requests
//      -> 5 accepted (response register + 4 FIFO entries), req_ready=0 with count=4,
//         rsp_data stable throughout; raising rsp_ready drains all 5 in order.
//  5 Full with simultaneous pop: count=4, rsp_ready=1, req_valid=1
//      -> no write on that edge, count=3; write accepted on the next edge.
//  6 Reset mid-operation: count=3, rsp_valid=1, pull rst_n low between edges
//      -> outputs clear immediately; after release no stale response appears and new requests work.

Source files
------------

// File: rtl/shift_req_queue.sv
// Request FIFO + registered response stage wrapped around a combinational barrel shifter.
// Head entry drives the shifter; its result is captured whenever the response slot is free.
module shift_req_queue #(
  parameter int DATA_W = 8,
  parameter int CTRL_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DATA_W-1:0]          req_data,
  input  logic [CTRL_W-1:0]          req_shamt,
  output logic [DATA_W-1:0]          sh_in,
  output logic [CTRL_W-1:0]          sh_ctrl,
  input  logic [DATA_W-1:0]          sh_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [CTRL_W-1:0]          rsp_shamt,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] shamt;
  } req_t;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, load;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  // An entry written this edge is not yet visible at the head, so push-into-empty never loads.
  assign load      = !empty && (!rsp_valid || rsp_ready);

  always_comb begin
    sh_in   = '0;
    sh_ctrl = '0;
    if (!empty) begin
      sh_in   = mem[rd_ptr].data;
      sh_ctrl = mem[rd_ptr].shamt;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: req_data, shamt: req_shamt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      if (push && !load)      count <= count + 1'b1;
      else if (load && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_shamt <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sh_out;
      rsp_shamt <= sh_ctrl;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_req_queue.sv
// Bench for shift_req_queue with a behavioural logical-right-shift in loop-back and a queue-based model.
module tb_shift_req_queue;
  localparam int DATA_W = 8;
  localparam int CTRL_W = 3;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, rsp_ready = 1'b0;
  logic [DATA_W-1:0] req_data = '0;
  logic [CTRL_W-1:0] req_shamt = '0;
  logic              req_ready, rsp_valid;
  logic [DATA_W-1:0] sh_in, sh_out, rsp_data;
  logic [CTRL_W-1:0] sh_ctrl, rsp_shamt;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  // Shifter contract: logical right shift, zero fill.
  assign sh_out = sh_in >> sh_ctrl;

  shift_req_queue #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_shamt(req_shamt),
    .sh_in(sh_in), .sh_ctrl(sh_ctrl), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_shamt(rsp_shamt),
    .count(count)
  );

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] s;
  } ent_t;

  int                checks = 0;
  int                errors = 0;
  ent_t              mq[$];
  logic              mv;
  logic [DATA_W-1:0] md;
  logic [CTRL_W-1:0] ms;
  logic [DATA_W-1:0] got[$];
  logic [DATA_W-1:0] acc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mv = 1'b0; md = '0; ms = '0;
  endtask

  task automatic check_all();
    chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
    chk("count", 32'(count), 32'(mq.size()));
    chk("rsp_valid", 32'(rsp_valid), 32'(mv));
    chk("rsp_data", 32'(rsp_data), 32'(md));
    chk("rsp_shamt", 32'(rsp_shamt), 32'(ms));
    chk("sh_in", 32'(sh_in), mq.size() > 0 ? 32'(mq[0].d) : 32'd0);
    chk("sh_ctrl", 32'(sh_ctrl), mq.size() > 0 ? 32'(mq[0].s) : 32'd0);
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare everything.
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] s,
                     input logic rr);
    int   n;
    logic push, load;
    ent_t e;
    req_valid = v; req_data = d; req_shamt = s; rsp_ready = rr;
    @(posedge clk);
    n    = mq.size();
    push = v && (n < DEPTH);
    load = (n > 0) && (!mv || rr);
    if (mv && rr) got.push_back(md);
    if (load) begin
      e = mq.pop_front();
      mv = 1'b1; md = e.d >> e.s; ms = e.s;
    end else if (mv && rr) begin
      mv = 1'b0;
    end
    if (push) begin
      mq.push_back('{d, s});
      acc.push_back(d >> s);
    end
    #1;
    check_all();
  endtask

  logic [DATA_W-1:0] sd [7];
  logic [CTRL_W-1:0] ss [7];
  logic [DATA_W-1:0] se [7];

  initial begin
    sd = '{8'd128, 8'd128, 8'd128, 8'd255, 8'd128, 8'd128, 8'd255};
    ss = '{3'd4, 3'd2, 3'd1, 3'd7, 3'd3, 3'd5, 3'd4};
    se = '{8'd8, 8'd32, 8'd64, 8'd1, 8'd16, 8'd4, 8'd15};
    model_reset();

    // Reset state
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_sh_in", 32'(sh_in), 32'd0);
    chk("rst_sh_ctrl", 32'(sh_ctrl), 32'd0);
    rst_n = 1'b1;

    // Single request: result one edge after acceptance
    cyc(1'b1, 8'd128, 3'd4, 1'b1);
    chk("single_pre_valid", 32'(rsp_valid), 32'd0);
    cyc(1'b0, 8'd0, 3'd0, 1'b1);
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_data", 32'(rsp_data), 32'd8);
    chk("single_shamt", 32'(rsp_shamt), 32'd4);
    cyc(1'b0, 8'd0, 3'd0, 1'b1);
    chk("single_drain", 32'(rsp_valid), 32'd0);

    // Back-to-back stream
    got.delete();
    for (int i = 0; i < 7; i++) cyc(1'b1, sd[i], ss[i], 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 3'd0, 1'b1);
    chk("stream_len", 32'(got.size()), 32'd7);
    for (int i = 0; i < 7 && i < got.size(); i++) chk("stream_data", 32'(got[i]), 32'(se[i]));

    // Backpressure: six offered, five held
    got.delete(); acc.delete();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'($urandom), 3'($urandom), 1'b0);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_ready", 32'(req_ready), 32'd0);
    chk("bp_accepted", 32'(acc.size()), 32'd5);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'd0, 3'd0, 1'b1);
    chk("bp_drained", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_order", 32'(got[i]), 32'(acc[i]));

    // Full with simultaneous pop: no write that edge, accepted next edge
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 3'($urandom), 1'b0);
    chk("full_count", 32'(count), 32'd4);
    cyc(1'b1, 8'hA5, 3'd1, 1'b1);
    chk("full_pop_count", 32'(count), 32'd3);
    cyc(1'b1, 8'h5A, 3'd2, 1'b1);
    chk("full_next_count", 32'(count), 32'd3);
    chk("mid_valid_pre", 32'(rsp_valid), 32'd1);

    // Async reset between edges
    rst_n = 1'b0;
    #2;
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_req_ready", 32'(req_ready), 32'd1);
    chk("mrst_sh_in", 32'(sh_in), 32'd0);
    model_reset();
    rst_n = 1'b1;
    cyc(1'b0, 8'd0, 3'd0, 1'b1);
    cyc(1'b1, 8'd200, 3'd3, 1'b1);
    cyc(1'b0, 8'd0, 3'd0, 1'b1);
    chk("post_rst_data", 32'(rsp_data), 32'd25);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
          1'($urandom_range(0, 2) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
